// File: rtl/eac_result_normalizer.sv
// Recovers magnitude and sign from the end-around-carry adder output, then left-normalises
// it over several cycles while tracking the exponent adjustment for the rounding stage.
module eac_result_normalizer #(
    parameter int unsigned ADDER_WIDTH = 74,
    parameter int unsigned SHIFT_STEP  = 8,
    parameter int unsigned ADJ_WIDTH   = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] sum,
    input  logic                   cout,
    input  logic                   sticky,
    input  logic                   effectiveOperation,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] mant,
    output logic [ADJ_WIDTH-1:0]   exp_adj,
    output logic                   sign_flip,
    output logic                   zero,
    output logic                   sticky_out
);

    localparam logic [ADJ_WIDTH-1:0] StepAdj = ADJ_WIDTH'(SHIFT_STEP);
    localparam logic [ADJ_WIDTH-1:0] OneAdj  = ADJ_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDER_WIDTH-1:0] mag_q, mag_d;
    logic [ADJ_WIDTH-1:0]   adj_q, adj_d;
    logic                   sign_flip_q, sign_flip_d;
    logic                   zero_q, zero_d;
    logic                   sticky_q, sticky_d;

    logic [ADDER_WIDTH-1:0] cap_mag;
    logic [ADJ_WIDTH-1:0]   cap_adj;
    logic                   cap_sign_flip;
    logic                   cap_sticky;

    // Magnitude recovery: invert on a subtraction without carry, absorb the carry on addition.
    always_comb begin
        cap_mag       = sum;
        cap_adj       = '0;
        cap_sign_flip = 1'b0;
        cap_sticky    = sticky;
        unique case ({effectiveOperation, cout})
            2'b11: cap_mag = sum;
            2'b10: begin
                cap_mag       = ~sum;
                cap_sign_flip = 1'b1;
            end
            2'b00: cap_mag = sum;
            2'b01: begin
                cap_mag    = {1'b1, sum[ADDER_WIDTH-1:1]};
                cap_sticky = sticky | sum[0];
                cap_adj    = OneAdj;
            end
            default: cap_mag = sum;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        adj_d       = adj_q;
        sign_flip_d = sign_flip_q;
        zero_d      = zero_q;
        sticky_d    = sticky_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mag_d       = cap_mag;
                    sign_flip_d = cap_sign_flip;
                    sticky_d    = cap_sticky;
                    if (cap_mag == '0) begin
                        zero_d  = 1'b1;
                        adj_d   = '0;
                        state_d = StDone;
                    end else begin
                        zero_d  = 1'b0;
                        adj_d   = cap_adj;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (mag_q[ADDER_WIDTH-1]) begin
                    state_d = StDone;
                end else if (mag_q[ADDER_WIDTH-1 -: SHIFT_STEP] == '0) begin
                    mag_d = mag_q << SHIFT_STEP;
                    adj_d = adj_q - StepAdj;
                end else begin
                    mag_d = mag_q << 1;
                    adj_d = adj_q - OneAdj;
                end
            end
            StDone: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            adj_q       <= '0;
            sign_flip_q <= 1'b0;
            zero_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            adj_q       <= adj_d;
            sign_flip_q <= sign_flip_d;
            zero_q      <= zero_d;
            sticky_q    <= sticky_d;
        end
    end

    // Gate with rst_n so no input is advertised while reset is held.
    assign in_ready   = rst_n && (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign mant       = mag_q;
    assign exp_adj    = adj_q;
    assign sign_flip  = sign_flip_q;
    assign zero       = zero_q;
    assign sticky_out = sticky_q;

endmodule
